demod_segment_bank: RTL and testbench

DEMOD_SEGMENT_BANK -- requirements
Module: demod_segment_bank

---
 rtl/demod_segment_bank_pkg.sv | 26 ++
 rtl/demod_slicer.sv | 25 ++
 rtl/demod_segment_bank.sv | 131 +++++++++++++
 tb/tb_demod_segment_bank.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demod_segment_bank_pkg.sv
// Shared definitions for the segment-bank demodulator: FSM states, fixed-point
// unity constants and the output count width.
package demod_segment_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // +1.0 in a format with FRAC fractional bits; callers truncate to WIDTH.
  function automatic logic signed [127:0] fx_pos_one(input int frac);
    return 128'sd1 <<< frac;
  endfunction

  // -1.0 in the same format (two's complement of +1.0).
  function automatic logic signed [127:0] fx_neg_one(input int frac);
    return -(128'sd1 <<< frac);
  endfunction

  // Width able to hold any count from 0 to nseg inclusive.
  function automatic int cnt_width(input int nseg);
    return $clog2(nseg + 1);
  endfunction

endpackage

// File: rtl/demod_slicer.sv
// Combinational per-segment slicer: picks ref or ref_m from a signed compare
// against the threshold and flags samples inside the +/-margin band.
module demod_slicer #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] sample_i,
  input  logic signed [WIDTH-1:0] threshold_i,
  input  logic signed [WIDTH-1:0] ref_i,
  input  logic signed [WIDTH-1:0] ref_m_i,
  input  logic        [WIDTH-1:0] margin_i,
  output logic signed [WIDTH-1:0] dec_o,
  output logic                    low_conf_o
);

  // One extra bit keeps sample - threshold exact over the full signed range.
  logic [WIDTH:0] diff;
  logic [WIDTH:0] mag;

  assign diff       = {sample_i[WIDTH-1], sample_i} - {threshold_i[WIDTH-1], threshold_i};
  assign mag        = diff[WIDTH] ? (~diff + 1'b1) : diff;
  assign low_conf_o = (mag < {1'b0, margin_i});
  // Ties fall to ref_m.
  assign dec_o      = (sample_i > threshold_i) ? ref_i : ref_m_i;

endmodule

// File: rtl/demod_segment_bank.sv
// Frame-based segment demodulator: collects NSEG samples, slices each against a
// frame-latched threshold, and publishes the decision words plus a count of
// low-confidence segments once per frame.
module demod_segment_bank
  import demod_segment_bank_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               FRAC        = 16,
  parameter int               NSEG        = 10,
  parameter logic [NSEG-1:0]  REF_PATTERN = NSEG'({32{2'b01}}),
  parameter logic [WIDTH-1:0] MARGIN      = WIDTH'(1) << (FRAC - 2),
  localparam int              CNT_W       = cnt_width(NSEG)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  input  logic signed [WIDTH-1:0] threshold,
  output logic                    busy,
  output logic                    valid,
  output logic [NSEG*WIDTH-1:0]   seg_out,
  output logic [CNT_W-1:0]        low_conf_count
);

  localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NSEG - 1);
  localparam logic signed [WIDTH-1:0] POS_ONE  = WIDTH'(fx_pos_one(FRAC));
  localparam logic signed [WIDTH-1:0] NEG_ONE  = WIDTH'(fx_neg_one(FRAC));

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [WIDTH-1:0] thr_q, thr_d;
  logic [NSEG*WIDTH-1:0]   work_q, work_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NSEG*WIDTH-1:0]   seg_q, seg_d;
  logic [CNT_W-1:0]        lcc_q, lcc_d;

  logic                    ref_bit;
  logic signed [WIDTH-1:0] ref_w, ref_m_w, dec_w;
  logic                    low_w;

  // Reference polarity for the segment currently being collected.
  always_comb begin
    ref_bit = 1'b0;
    for (int i = 0; i < NSEG; i++) begin
      if (int'(idx_q) == i) ref_bit = REF_PATTERN[i];
    end
  end

  assign ref_w   = ref_bit ? POS_ONE : NEG_ONE;
  assign ref_m_w = ref_bit ? NEG_ONE : POS_ONE;

  demod_slicer #(
    .WIDTH (WIDTH)
  ) u_slicer (
    .sample_i    (sample_in),
    .threshold_i (thr_q),
    .ref_i       (ref_w),
    .ref_m_i     (ref_m_w),
    .margin_i    (MARGIN),
    .dec_o       (dec_w),
    .low_conf_o  (low_w)
  );

  // Frame sequencing, working-register updates and the end-of-frame output load.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    thr_d   = thr_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    lcc_d   = lcc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          thr_d   = threshold;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (sample_valid) begin
          for (int i = 0; i < NSEG; i++) begin
            if (int'(idx_q) == i) work_d[i*WIDTH +: WIDTH] = dec_w;
          end
          if (low_w) cnt_d = cnt_q + CNT_W'(1);
          if (idx_q == LAST_IDX) begin
            // Publish including the segment accepted this cycle.
            seg_d   = work_d;
            lcc_d   = cnt_d;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any frame and clears every output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      thr_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      seg_q   <= '0;
      lcc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      thr_q   <= thr_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      lcc_q   <= lcc_d;
    end
  end

  assign busy           = (state_q == ST_COLLECT);
  assign valid          = (state_q == ST_DONE);
  assign seg_out        = seg_q;
  assign low_conf_count = lcc_q;

endmodule

// File: tb/tb_demod_segment_bank.sv
// Self-checking bench for demod_segment_bank: directed and randomized frames
// against a behavioural model, plus NSEG=1 / NSEG=64 tie cases.
module tb_demod_segment_bank;

  localparam logic [31:0] P1   = 32'h0001_0000;
  localparam logic [31:0] M1   = 32'hFFFF_0000;
  localparam longint      MARG = 64'd16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic               start_a, sv_a;
  logic signed [31:0] samp_a, thr_a;
  logic               busy_a, valid_a;
  logic [319:0]       seg_a;
  logic [3:0]         cnt_a;

  logic               start_b, sv_b;
  logic signed [31:0] samp_b, thr_b;
  logic               busy_1, valid_1, busy_64, valid_64;
  logic [31:0]        seg_1;
  logic [0:0]         cnt_1;
  logic [2047:0]      seg_64;
  logic [6:0]         cnt_64;

  demod_segment_bank u_a (
    .clk(clk), .reset(reset), .start(start_a), .sample_in(samp_a), .sample_valid(sv_a),
    .threshold(thr_a), .busy(busy_a), .valid(valid_a), .seg_out(seg_a), .low_conf_count(cnt_a));

  demod_segment_bank #(.NSEG(1)) u_1 (
    .clk(clk), .reset(reset), .start(start_b), .sample_in(samp_b), .sample_valid(sv_b),
    .threshold(thr_b), .busy(busy_1), .valid(valid_1), .seg_out(seg_1), .low_conf_count(cnt_1));

  demod_segment_bank #(.NSEG(64)) u_64 (
    .clk(clk), .reset(reset), .start(start_b), .sample_in(samp_b), .sample_valid(sv_b),
    .threshold(thr_b), .busy(busy_64), .valid(valid_64), .seg_out(seg_64), .low_conf_count(cnt_64));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vpulses_a = 0;
  always @(negedge clk) if (valid_a) vpulses_a <= vpulses_a + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Modelled published outputs of the default instance.
  logic [31:0] exp_seg[10];
  int          exp_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: decision is +1.0 when (sample above threshold) agrees
  // with the pattern bit, else -1.0; low confidence is |s - t| < 0.25.
  function automatic logic [31:0] model_dec(input bit pbit, input int s, input int t);
    return ((s > t) == pbit) ? P1 : M1;
  endfunction

  function automatic bit model_low(input int s, input int t);
    longint d;
    d = longint'(s) - longint'(t);
    if (d < 0) d = -d;
    return d < MARG;
  endfunction

  function automatic int rnd_near(input int thr);
    int off[5] = '{-16384, -16383, 0, 16383, 16384};
    case ($urandom_range(0, 3))
      0:       return int'($urandom);
      1:       return thr + off[$urandom_range(0, 4)];
      default: return thr + int'($urandom_range(0, 262144)) - 131072;
    endcase
  endfunction

  task automatic check_outputs_a(input string tag);
    for (int k = 0; k < 10; k++)
      check($sformatf("%s_seg%0d", tag, k), seg_a[k*32 +: 32], exp_seg[k]);
    check({tag, "_cnt"}, cnt_a, exp_cnt);
  endtask

  task automatic frame_a(input int s[10], input int thr, input bit gaps, input bit poke);
    logic [31:0] fseg[10];
    int fcnt, fa, v0;
    fcnt = 0;
    for (int k = 0; k < 10; k++) begin
      fseg[k] = model_dec((k % 2) == 0, s[k], thr);
      fcnt += int'(model_low(s[k], thr));
    end
    v0 = vpulses_a;
    fa = 0;
    start_a = 1'b1; thr_a = thr; sv_a = 1'b0;
    tick();
    start_a = 1'b0;
    check("busy_after_start", busy_a, 1);
    thr_a = $urandom;
    for (int k = 0; k < 10; k++) begin
      if (gaps)
        for (int g = 0; g < 4 && $urandom_range(0, 2) == 0; g++) begin
          sv_a = 1'b0; samp_a = $urandom; thr_a = $urandom;
          start_a = poke ? 1'($urandom_range(0, 1)) : 1'b0;
          tick();
        end
      sv_a = 1'b1; samp_a = s[k];
      start_a = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (k == 0) fa = cyc;
      if (k < 9) check("valid_early", valid_a, 0);
    end
    // Now in the DONE cycle: stray sample and start must both be ignored.
    sv_a = 1'b1; samp_a = $urandom; start_a = poke;
    check("valid_pulse", valid_a, 1);
    check("busy_in_done", busy_a, 0);
    if (!gaps) check("first_to_valid_cycles", cyc + 1 - fa, 10);
    for (int k = 0; k < 10; k++) exp_seg[k] = fseg[k];
    exp_cnt = fcnt;
    check_outputs_a("done");
    tick();
    start_a = 1'b0;
    check("valid_one_cycle", valid_a, 0);
    check("busy_after_done", busy_a, 0);
    check("pulse_count", vpulses_a - v0, 1);
    for (int i = 0; i < 3; i++) begin
      sv_a = 1'($urandom_range(0, 1)); samp_a = $urandom;
      tick();
    end
    sv_a = 1'b0;
    check("idle_busy", busy_a, 0);
    check_outputs_a("hold");
  endtask

  task automatic reset_abort();
    int v0;
    v0 = vpulses_a;
    start_a = 1'b1; thr_a = 0;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sv_a = 1'b1; samp_a = $urandom;
      tick();
    end
    reset = 1'b1; sv_a = 1'b1; start_a = 1'b1;
    tick();
    reset = 1'b0; sv_a = 1'b0; start_a = 1'b0;
    for (int k = 0; k < 10; k++) exp_seg[k] = '0;
    exp_cnt = 0;
    check("abort_busy", busy_a, 0);
    check_outputs_a("abort");
    for (int i = 0; i < 14; i++) begin
      sv_a = 1'($urandom_range(0, 1)); samp_a = $urandom;
      tick();
    end
    sv_a = 1'b0;
    check("abort_no_pulse", vpulses_a - v0, 0);
    check_outputs_a("abort_hold");
  endtask

  task automatic frame_b(input int thr);
    int s[64];
    int c64;
    c64 = 0;
    for (int k = 0; k < 64; k++) begin
      s[k] = ((k % 4) == 0) ? thr : rnd_near(thr);
      c64 += int'(model_low(s[k], thr));
    end
    start_b = 1'b1; thr_b = thr;
    tick();
    start_b = 1'b0; thr_b = $urandom;
    check("b_busy1", busy_1, 1);
    check("b_busy64", busy_64, 1);
    for (int k = 0; k < 64; k++) begin
      sv_b = 1'b1; samp_b = s[k];
      tick();
      if (k == 0) begin
        check("n1_valid", valid_1, 1);
        check("n1_seg", seg_1, model_dec(1'b1, s[0], thr));
        check("n1_cnt", cnt_1, 1);
      end
      if (k == 1) check("n1_idle", {busy_1, valid_1}, 0);
      if (k < 63) check("n64_valid_early", valid_64, 0);
    end
    sv_b = 1'b0;
    check("n64_valid", valid_64, 1);
    check("n64_busy", busy_64, 0);
    for (int k = 0; k < 64; k++)
      check($sformatf("n64_seg%0d", k), seg_64[k*32 +: 32], model_dec((k % 2) == 0, s[k], thr));
    check("n64_cnt", cnt_64, c64);
    tick();
    check("n64_valid_off", valid_64, 0);
    check("n1_hold_seg", seg_1, model_dec(1'b1, s[0], thr));
  endtask

  initial begin
    int dir[10] = '{32768, -32768, 131072, -131072, 0, 6554, -6554, 65536, -65536, 19661};
    logic [31:0] dir_exp[10] = '{P1, P1, P1, P1, M1, M1, M1, M1, M1, M1};
    int s[10];
    int thr;

    reset = 1'b1;
    start_a = 1'b0; sv_a = 1'b0; samp_a = '0; thr_a = '0;
    start_b = 1'b0; sv_b = 1'b0; samp_b = '0; thr_b = '0;
    for (int k = 0; k < 10; k++) exp_seg[k] = '0;
    exp_cnt = 0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", busy_a, 0);
    check("rst_valid", valid_a, 0);
    check_outputs_a("rst");
    check("rst_b", {busy_1, valid_1, busy_64, valid_64, cnt_1, cnt_64}, 0);
    check("rst_seg64", (seg_64 == '0 && seg_1 == '0) ? 1 : 0, 1);

    // Reset wins over a simultaneous start.
    reset = 1'b1; start_a = 1'b1;
    tick();
    reset = 1'b0; start_a = 1'b0;
    check("rst_prio_busy", busy_a, 0);

    frame_a(dir, 0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++)
      check($sformatf("dir_seg%0d", k), seg_a[k*32 +: 32], dir_exp[k]);
    check("dir_cnt", cnt_a, 3);

    frame_a(dir, 0, 1'b1, 1'b0);
    frame_a(dir, 0, 1'b1, 1'b1);

    reset_abort();
    frame_a(dir, 0, 1'b0, 1'b0);

    // Extreme operands: the difference needs the extra bit.
    thr = -2147483647 - 1;
    for (int k = 0; k < 10; k++) s[k] = ((k % 2) == 0) ? 2147483647 : thr;
    frame_a(s, thr, 1'b0, 1'b0);

    for (int f = 0; f < 12; f++) begin
      thr = int'($urandom_range(0, 536870912)) - 268435456;
      for (int k = 0; k < 10; k++) s[k] = rnd_near(thr);
      frame_a(s, thr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    frame_b(32'h0000_8000);
    frame_b(int'($urandom_range(0, 1048576)) - 524288);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
